// File: rtl/mask_centroid_marker.sv
`default_nettype none
// ============================================================================
// mask_centroid_marker: per-frame centroid of a binary mask, with a cross
// marker overlaid on the video at the last valid centroid.   Rev 1.0
// ============================================================================
module mask_centroid_marker #(
  parameter int          X_WIDTH      = 11,
  parameter int          Y_WIDTH      = 11,
  parameter int          MARKER_HALF  = 8,
  parameter logic [23:0] MARKER_COLOR = 24'hff0000,
  parameter int          MIN_COUNT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic [23:0]        pixel_in,
  output logic               de_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [23:0]        pixel_out,
  output logic [X_WIDTH-1:0] centroid_x,
  output logic [Y_WIDTH-1:0] centroid_y,
  output logic               centroid_valid,
  output logic               result_stb
);

  localparam int CNT_W  = X_WIDTH + Y_WIDTH;
  localparam int SX_W   = CNT_W + X_WIDTH;
  localparam int SY_W   = CNT_W + Y_WIDTH;
  localparam int DIV_N  = (SX_W > SY_W) ? SX_W : SY_W;
  localparam int STEP_W = $clog2(DIV_N);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [X_WIDTH-1:0] r_x;
  logic [Y_WIDTH-1:0] r_y;
  logic               r_de_prev;
  logic               r_vs_prev;
  logic [SX_W-1:0]    r_sum_x;
  logic [SY_W-1:0]    r_sum_y;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_state;
  logic [STEP_W-1:0]  r_step;
  logic               r_res_valid;
  logic [CNT_W-1:0]   r_divisor;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [DIV_N-1:0]   r_qx;
  logic [DIV_N-1:0]   r_qy;
  logic [CNT_W-1:0]   r_rem_x;
  logic [CNT_W-1:0]   r_rem_y;

  logic               w_frame_end;
  logic               w_hit;
  logic               w_start_div;
  logic [CNT_W:0]     w_trial_x;
  logic [CNT_W:0]     w_trial_y;
  logic               w_ge_x;
  logic               w_ge_y;
  logic [X_WIDTH-1:0] w_dx;
  logic [Y_WIDTH-1:0] w_dy;
  logic               w_mark;

  assign w_frame_end = v_sync_in & ~r_vs_prev;
  assign w_hit       = de_in & pixel_in[0];
  assign w_start_div = (r_count >= CNT_W'(MIN_COUNT)) && (r_count != '0);

  assign w_trial_x = {r_rem_x, r_qx[DIV_N-1]};
  assign w_trial_y = {r_rem_y, r_qy[DIV_N-1]};
  assign w_ge_x    = w_trial_x >= {1'b0, r_divisor};
  assign w_ge_y    = w_trial_y >= {1'b0, r_divisor};

  assign w_dx   = (r_x >= centroid_x) ? (r_x - centroid_x) : (centroid_x - r_x);
  assign w_dy   = (r_y >= centroid_y) ? (r_y - centroid_y) : (centroid_y - r_y);
  assign w_mark = centroid_valid & de_in &
                  (((r_x == centroid_x) && (w_dy <= Y_WIDTH'(MARKER_HALF))) ||
                   ((r_y == centroid_y) && (w_dx <= X_WIDTH'(MARKER_HALF))));

  // Position tracking and accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_de_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_sum_x   <= '0;
      r_sum_y   <= '0;
      r_count   <= '0;
    end else begin
      r_de_prev <= de_in;
      r_vs_prev <= v_sync_in;
      if (w_frame_end) begin
        r_x <= '0;
        r_y <= '0;
      end else if (de_in) begin
        if (r_x != '1) r_x <= r_x + X_WIDTH'(1);
      end else if (r_de_prev) begin
        r_x <= '0;
        if (r_y != '1) r_y <= r_y + Y_WIDTH'(1);
      end
      // A pixel coinciding with the frame-end edge belongs to the next frame.
      if (w_frame_end) begin
        r_sum_x <= w_hit ? SX_W'(r_x) : '0;
        r_sum_y <= w_hit ? SY_W'(r_y) : '0;
        r_count <= w_hit ? CNT_W'(1) : '0;
      end else if (w_hit) begin
        r_sum_x <= r_sum_x + SX_W'(r_x);
        r_sum_y <= r_sum_y + SY_W'(r_y);
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Divider control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_step         <= '0;
      r_res_valid    <= 1'b0;
      r_divisor      <= '0;
      r_qx           <= '0;
      r_qy           <= '0;
      r_rem_x        <= '0;
      r_rem_y        <= '0;
      centroid_x     <= '0;
      centroid_y     <= '0;
      centroid_valid <= 1'b0;
      result_stb     <= 1'b0;
    end else begin
      result_stb <= 1'b0;
      case (r_state)
        S_DIVIDE: begin
          r_rem_x <= w_ge_x ? CNT_W'(w_trial_x - {1'b0, r_divisor}) : w_trial_x[CNT_W-1:0];
          r_rem_y <= w_ge_y ? CNT_W'(w_trial_y - {1'b0, r_divisor}) : w_trial_y[CNT_W-1:0];
          r_qx    <= {r_qx[DIV_N-2:0], w_ge_x};
          r_qy    <= {r_qy[DIV_N-2:0], w_ge_y};
          if (r_step == STEP_W'(DIV_N - 1)) r_state <= S_DONE;
          else                              r_step  <= r_step + STEP_W'(1);
        end
        S_DONE: begin
          result_stb     <= 1'b1;
          centroid_valid <= r_res_valid;
          if (r_res_valid) begin
            centroid_x <= r_qx[X_WIDTH-1:0];
            centroid_y <= r_qy[Y_WIDTH-1:0];
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A new frame end always wins, discarding any division still in flight.
      if (w_frame_end) begin
        r_qx        <= DIV_N'(r_sum_x);
        r_qy        <= DIV_N'(r_sum_y);
        r_rem_x     <= '0;
        r_rem_y     <= '0;
        r_divisor   <= r_count;
        r_step      <= '0;
        r_res_valid <= w_start_div;
        r_state     <= w_start_div ? S_DIVIDE : S_DONE;
      end
    end
  end

  // Video path
  always_ff @(posedge clk) begin
    if (rst) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end else begin
      de_out     <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;
      pixel_out  <= w_mark ? MARKER_COLOR : pixel_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mask_centroid_marker.sv
`default_nettype none
// Bench for mask_centroid_marker: two instances (MIN_COUNT 1 and 16) share one
// video stream; a frame-level model predicts centroids, strobes and overlay.
module tb_mask_centroid_marker;

  localparam int          XW    = 11;
  localparam int          YW    = 11;
  localparam int          HALF  = 1;
  localparam int          DIV_N = XW + YW + XW;
  localparam logic [23:0] RED   = 24'hff0000;
  localparam logic [23:0] WHITE = 24'hffffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, de, hs, vs;
  logic [23:0] pix;
  logic        de_o [2];
  logic        hs_o [2];
  logic        vs_o [2];
  logic        cv_o [2];
  logic        stb_o[2];
  logic [23:0] pix_o[2];
  logic [XW-1:0] cx_o[2];
  logic [YW-1:0] cy_o[2];

  mask_centroid_marker #(.X_WIDTH(XW), .Y_WIDTH(YW), .MARKER_HALF(HALF),
                         .MARKER_COLOR(RED), .MIN_COUNT(1)) dut_a (
    .clk(clk), .rst(rst), .de_in(de), .h_sync_in(hs), .v_sync_in(vs), .pixel_in(pix),
    .de_out(de_o[0]), .h_sync_out(hs_o[0]), .v_sync_out(vs_o[0]), .pixel_out(pix_o[0]),
    .centroid_x(cx_o[0]), .centroid_y(cy_o[0]), .centroid_valid(cv_o[0]), .result_stb(stb_o[0]));

  mask_centroid_marker #(.X_WIDTH(XW), .Y_WIDTH(YW), .MARKER_HALF(HALF),
                         .MARKER_COLOR(RED), .MIN_COUNT(16)) dut_b (
    .clk(clk), .rst(rst), .de_in(de), .h_sync_in(hs), .v_sync_in(vs), .pixel_in(pix),
    .de_out(de_o[1]), .h_sync_out(hs_o[1]), .v_sync_out(vs_o[1]), .pixel_out(pix_o[1]),
    .centroid_x(cx_o[1]), .centroid_y(cy_o[1]), .centroid_valid(cv_o[1]), .result_stb(stb_o[1]));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance
  int     min_cnt[2];
  logic [XW-1:0] m_cx[2];
  logic [YW-1:0] m_cy[2];
  bit     m_val[2];
  int     m_pend[2];
  int     m_pcx[2], m_pcy[2];
  bit     m_pval[2];
  int     qx[$], qy[$];
  bit     prev_v = 1'b0;
  int     marks[2], stbs[2], last_stb_t[2];
  int     tcount = 0;

  typedef struct {
    logic [47:0] mask;
    int a_cx; int a_cy; bit a_v;
    int b_cx; int b_cy; bit b_v;
    int a_marks; int b_marks;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int unit, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @tick %0d: got %0h expected %0h", name, unit, tcount, act, exp);
    end
  endtask

  function automatic bit on_cross(int c, int r, int cx, int cy);
    return (c == cx && r - cy <= HALF && cy - r <= HALF) ||
           (r == cy && c - cx <= HALF && cx - c <= HALF);
  endfunction

  task automatic tick(input bit d, input bit h, input bit v, input logic [23:0] p,
                      input int col, input int row);
    logic [23:0] exp_pix[2];
    bit exp_stb[2];
    bit new_frame;
    int sx, sy, n;
    de = d; hs = h; vs = v; pix = p;
    for (int u = 0; u < 2; u++)
      exp_pix[u] = (m_val[u] && d && on_cross(col, row, int'(m_cx[u]), int'(m_cy[u]))) ? RED : p;
    new_frame = !rst && v && !prev_v;
    @(posedge clk);
    #1;
    tcount++;
    if (rst) begin
      prev_v = 1'b0;
      qx.delete();
      qy.delete();
      for (int u = 0; u < 2; u++) begin
        m_val[u] = 1'b0; m_cx[u] = '0; m_cy[u] = '0; m_pend[u] = 0;
        chk("reset_outputs", u, {de_o[u], hs_o[u], vs_o[u], pix_o[u], cx_o[u], cy_o[u],
                                 cv_o[u], stb_o[u]}, 64'd0);
      end
      return;
    end
    prev_v = v;
    for (int u = 0; u < 2; u++) begin
      exp_stb[u] = 1'b0;
      if (m_pend[u] > 0) begin
        m_pend[u]--;
        if (m_pend[u] == 0) begin
          exp_stb[u] = 1'b1;
          m_val[u]   = m_pval[u];
          if (m_pval[u]) begin
            m_cx[u] = XW'(m_pcx[u]);
            m_cy[u] = YW'(m_pcy[u]);
          end
        end
      end
    end
    if (new_frame) begin
      sx = 0; sy = 0; n = qx.size();
      for (int i = 0; i < n; i++) begin
        sx += qx[i];
        sy += qy[i];
      end
      for (int u = 0; u < 2; u++) begin
        m_pval[u] = (n >= min_cnt[u]) && (n > 0);
        m_pend[u] = m_pval[u] ? DIV_N + 1 : 1;
        m_pcx[u]  = (n > 0) ? sx / n : 0;
        m_pcy[u]  = (n > 0) ? sy / n : 0;
      end
      qx.delete();
      qy.delete();
    end
    if (d && p[0]) begin
      qx.push_back(col);
      qy.push_back(row);
    end
    for (int u = 0; u < 2; u++) begin
      chk("video", u, {de_o[u], hs_o[u], vs_o[u], pix_o[u]}, {d, h, v, exp_pix[u]});
      chk("result_stb", u, {63'd0, stb_o[u]}, {63'd0, exp_stb[u]});
      chk("centroid", u, {cv_o[u], cx_o[u], cy_o[u]}, {m_val[u], m_cx[u], m_cy[u]});
      if (pix_o[u] === RED) marks[u]++;
      if (stb_o[u] === 1'b1) begin
        stbs[u]++;
        last_stb_t[u] = tcount;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
  endtask

  task automatic send_frame(input logic [255:0] m, input int w, input int h,
                            input int vhi, input int vlo);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) tick(1'b1, 1'b0, 1'b0, m[r*w+c] ? WHITE : 24'h0, c, r);
      tick(1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
      tick(1'b0, 1'b1, 1'b0, 24'h0, -1, -1);
      tick(1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
    end
    idle(2);
    for (int i = 0; i < vhi; i++) tick(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    idle(vlo);
  endtask

  task automatic clear_counts();
    for (int u = 0; u < 2; u++) begin
      marks[u] = 0; stbs[u] = 0; last_stb_t[u] = -1;
    end
  endtask

  initial begin
    logic [255:0] rm;
    int rw, rh, e2;
    min_cnt[0] = 1;
    min_cnt[1] = 16;
    //           mask                 a:cx cy v  b:cx cy v  marks a b
    tbl[0] = '{48'h0000_1400_1400,    3, 2, 1,   0, 0, 0,   0, 0};
    tbl[1] = '{48'h0000_0000_0006,    1, 0, 1,   0, 0, 0,   5, 0};
    tbl[2] = '{48'h000F_FFFF_0000,    3, 2, 1,   3, 2, 1,   4, 0};
    tbl[3] = '{48'h8000_0000_0081,    4, 1, 1,   3, 2, 0,   5, 5};
    tbl[4] = '{48'h0000_0000_0000,    4, 1, 0,   3, 2, 0,   5, 0};
    tbl[5] = '{48'h0000_1400_1400,    3, 2, 1,   3, 2, 0,   0, 0};

    rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; pix = '0;
    clear_counts();
    idle(3);
    rst = 1'b0;
    idle(4);

    // Table-driven 8x6 frames
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      send_frame(256'(tbl[i].mask), 8, 6, 3, 40);
      chk("tbl_a_centroid", 0, {cv_o[0], cx_o[0], cy_o[0]},
          {tbl[i].a_v, XW'(tbl[i].a_cx), YW'(tbl[i].a_cy)});
      chk("tbl_b_centroid", 1, {cv_o[1], cx_o[1], cy_o[1]},
          {tbl[i].b_v, XW'(tbl[i].b_cx), YW'(tbl[i].b_cy)});
      chk("tbl_a_marks", 0, 64'(marks[0]), 64'(tbl[i].a_marks));
      chk("tbl_b_marks", 1, 64'(marks[1]), 64'(tbl[i].b_marks));
      chk("tbl_a_stb_count", 0, 64'(stbs[0]), 64'd1);
      chk("tbl_b_stb_count", 1, 64'(stbs[1]), 64'd1);
    end

    // Second frame end arrives while the first division is in flight
    clear_counts();
    send_frame(256'(tbl[0].mask), 8, 6, 1, 0);
    tick(1'b1, 1'b0, 1'b0, 24'h0, 0, 0);
    tick(1'b1, 1'b0, 1'b0, WHITE, 1, 0);
    tick(1'b1, 1'b0, 1'b0, WHITE, 2, 0);
    tick(1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
    tick(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    e2 = tcount;
    tick(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    idle(42);
    chk("restart_stb_count", 0, 64'(stbs[0]), 64'd1);
    chk("restart_latency", 0, 64'(last_stb_t[0] - e2), 64'(DIV_N + 1));
    chk("restart_centroid", 0, {cv_o[0], cx_o[0], cy_o[0]}, {1'b1, XW'(1), YW'(0)});
    chk("restart_b_stb_count", 1, 64'(stbs[1]), 64'd2);

    // Reset during division and mid-line, then a full frame
    send_frame(256'(tbl[0].mask), 8, 6, 1, 0);
    idle(3);
    tick(1'b1, 1'b0, 1'b0, WHITE, 0, 0);
    clear_counts();
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0, WHITE, 1, 0);
    tick(1'b1, 1'b0, 1'b0, WHITE, 2, 0);
    rst = 1'b0;
    idle(40);
    chk("post_reset_no_stb", 0, 64'(stbs[0]), 64'd0);
    send_frame(256'(tbl[2].mask), 8, 6, 3, 40);
    chk("post_reset_a", 0, {cv_o[0], cx_o[0], cy_o[0]}, {1'b1, XW'(3), YW'(2)});
    chk("post_reset_b", 1, {cv_o[1], cx_o[1], cy_o[1]}, {1'b1, XW'(3), YW'(2)});

    // Randomised frames against the model
    for (int f = 0; f < 20; f++) begin
      rw = $urandom_range(4, 12);
      rh = $urandom_range(3, 8);
      rm = '0;
      for (int b = 0; b < rw * rh; b++)
        rm[b] = (f % 3 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      send_frame(rm, rw, rh, 3, 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mask_centroid_marker.md
Name: mask_centroid_marker

Overview:
- Sits directly downstream of the dilatation stage and consumes its binary video: pixel_in is 24'hffffff or 24'h0, and the mask is bit 0.
- Per frame: tracks the pixel position, accumulates the coordinate sums and count of mask pixels, and at frame end computes the integer centroid with a sequential divider.
- Passes the video through with 1-cycle latency and overlays a cross marker at the most recent valid centroid.

Parameters:
- X_WIDTH, 11, width of the column counter and centroid_x.
- Y_WIDTH, 11, width of the row counter and centroid_y.
- MARKER_HALF, 8, arm half-length of the overlay cross, in pixels.
- MARKER_COLOR, 24'hff0000, overlay colour.
- MIN_COUNT, 16, minimum mask-pixel count for a frame result to be valid.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- de_in  in  1  data enable from the dilatation stage.
- h_sync_in  in  1  horizontal sync; passed through only.
- v_sync_in  in  1  vertical sync, active-high; its rising edge marks frame end.
- pixel_in  in  24  binary video; bit 0 is the mask.
- de_out  out  1  de_in delayed 1 cycle.
- h_sync_out  out  1  h_sync_in delayed 1 cycle.
- v_sync_out  out  1  v_sync_in delayed 1 cycle.
- pixel_out  out  24  pixel_in delayed 1 cycle, with the marker overlaid.
- centroid_x  out  X_WIDTH  last computed centroid column (floor).
- centroid_y  out  Y_WIDTH  last computed centroid row (floor).
- centroid_valid  out  1  the last result met MIN_COUNT.
- result_stb  out  1  1-cycle pulse when centroid_* update.

Behaviour:
- Widths:
  - CNT_W = X_WIDTH+Y_WIDTH.
  - SX_W = CNT_W+X_WIDTH.
  - SY_W = CNT_W+Y_WIDTH.
  - DIV_N = max(SX_W, SY_W).
- Reset: all outputs 0, counters and accumulators 0, FSM to IDLE, internal v_sync_prev 0. Reset during DIVIDE aborts the division; there is no result_stb.
- Position tracking:
  - x increments each cycle de_in=1. It is cleared on the cycle after de_in falls and saturates at all-ones.
  - y increments on each de_in falling edge (1 then 0) and saturates.
  - x and y are both cleared on the v_sync rising edge.
  - The pixel under de_in has coordinates (x,y) as they stood before that cycle's increment; the first pixel of a frame is (0,0).
- Accumulation: when de_in=1 and pixel_in[0]=1, sum_x += x, sum_y += y, count += 1. The count saturates at all-ones.
- Frame end: edge = v_sync_in & ~v_sync_prev, sampled at posedge N. At N:
  - sum_x, sum_y and count are latched into the divider.
  - The accumulators are cleared. If de_in=1 in that cycle, the pixel is accumulated into the new frame.
- FSM, states IDLE, DIVIDE, DONE:
  - IDLE -> DIVIDE on edge when count >= MIN_COUNT and count != 0.
  - IDLE -> DONE on edge when count < MIN_COUNT. In this case centroid_valid <= 0 and centroid_x/y hold.
  - DIVIDE: two parallel restoring dividers (sum_x/count and sum_y/count), 1 quotient bit per cycle for DIV_N cycles, then -> DONE.
  - DONE (one cycle): for a valid result, centroid_x/y <= quotient truncated to width and centroid_valid <= 1. result_stb=1. Then -> IDLE.
  - An edge while in DIVIDE discards the in-flight division and restarts DIVIDE with the new sums. The same count >= MIN_COUNT check applies.
- Latency: a valid result pulses result_stb in the cycle after posedge N+DIV_N+1; an invalid result pulses it after posedge N+1.
- Video path: de/h_sync/v_sync are registered (1 cycle). pixel_out <= MARKER_COLOR when all of the following hold, else pixel_in:
  - centroid_valid=1;
  - de_in=1;
  - either (x==cx and |y-cy| <= MARKER_HALF) or (y==cy and |x-cx| <= MARKER_HALF).
- The overlay uses the centroid_* values present during the pixel's cycle, so an update takes effect immediately. Marker arms are clipped naturally at frame borders; there is no wrap.

Test Plan:
- 8x6 active frame with MIN_COUNT=1; mask at (2,1),(4,1),(2,3),(4,3) -> after v_sync rising, result_stb one cycle after posedge N+DIV_N+1, centroid=(3,2), valid=1.
- Same frame, mask only at (1,0),(2,0) -> centroid_x=1 (3/2 floored), centroid_y=0.
- Frame with 3 mask pixels and MIN_COUNT=16 -> result_stb one cycle after posedge N+1, valid=0, centroid_x/y unchanged, and no marker on the following frame.
- Next frame after centroid (3,2), MARKER_HALF=1 -> pixel_out=ff0000 at exactly (3,1),(3,2),(3,3),(2,2),(4,2); all other pixels equal pixel_in delayed 1 cycle, with syncs delayed 1 cycle.
- Second v_sync rising edge 5 cycles into DIVIDE -> no stale result_stb; a single result_stb DIV_N+1 cycles after the second edge, carrying the second frame's centroid.
- rst asserted mid-DIVIDE and mid-line -> on the next cycle all outputs are 0 and there is no result_stb; a following full frame yields the correct centroid.
